mem_tp_ctrl: RTL and testbench
==============================

Name: mem_tp_ctrl

Overview:
- Sequencing controller in front of a two-port bit-write memory: write port A, read port B with 1-cycle registered read.
- Presents valid/ready write and read-request channels, plus a 2-entry read-response buffer with backpressure.
- Blocks same-cycle same-address write/read hazards.
- Runs a zero-fill init sweep after reset and on request; sits between the NoC/DTU-side logic and the memory wrapper.

Parameters:
- MEM_DATAWIDTH, 128, data and bit-mask width
- MEM_ADDRWIDTH, 14, word-address width; depth = 2^MEM_ADDRWIDTH
- INIT_EN, 1, 1 = zero-fill whole memory after reset; 0 = memory usable immediately after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- init_req  in  1  one-cycle pulse; requests a zero-fill sweep
- init_busy  out  1  high while an init is pending or running
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted
- wr_addr  in  MEM_ADDRWIDTH  write address
- wr_mask  in  MEM_DATAWIDTH  bit-wise write enable
- wr_data  in  MEM_DATAWIDTH  write data
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted
- rd_addr  in  MEM_ADDRWIDTH  read address
- rdata_valid  out  1  response valid
- rdata_ready  in  1  response consumed
- rdata  out  MEM_DATAWIDTH  response data
- mem_ena  out  1  memory port A enable
- mem_wea  out  MEM_DATAWIDTH  memory bit write enable
- mem_addra  out  MEM_ADDRWIDTH  memory write address
- mem_dina  out  MEM_DATAWIDTH  memory write data
- mem_enb  out  1  memory port B enable
- mem_addrb  out  MEM_ADDRWIDTH  memory read address
- mem_doutb  in  MEM_DATAWIDTH  memory read data, valid the cycle after mem_enb

Behaviour:
- Reset values:
  - state = INIT if INIT_EN, else RUN
  - init counter = 0
  - init_busy = INIT_EN
  - rdata_valid = 0; response FIFO empty; inflight = 0; init-pending = 0
  - wr_ready = rd_ready = 0 during the reset cycle
  - mem_ena = mem_enb = 0
- States:
  - INIT: each cycle drives mem_ena=1, mem_wea=all-ones, mem_dina=0, mem_addra=counter; counter increments.
  - INIT -> RUN after writing address 2^MEM_ADDRWIDTH-1, so INIT lasts exactly 2^MEM_ADDRWIDTH cycles.
  - RUN: wr_ready and rd_ready as defined below; init_busy = init-pending.
  - init_req in RUN sets init-pending, which forces wr_ready = rd_ready = 0.
  - RUN -> INIT when init-pending and inflight = 0. Counter resets to 0, pending clears.
  - init_req during INIT is ignored.
- Write path:
  - wr_ready = (state == RUN) && !init-pending.
  - On wr_valid && wr_ready, in the same cycle: mem_ena=1, mem_wea=wr_mask, mem_addra=wr_addr, mem_dina=wr_data.
  - Otherwise mem_ena=0 and mem_wea=0.
  - An all-zero mask is still accepted (no-op write).
- Read path:
  - rd_ready = RUN && !init-pending && space && !collision.
    - collision = wr_valid && wr_ready && (wr_addr == rd_addr); the write wins and the read waits, so it observes the new data next cycle.
    - space = (fifo_count + inflight − pop) < 2, where pop = rdata_valid && rdata_ready.
  - On read fire in cycle N: mem_enb=1, mem_addrb=rd_addr, inflight set.
  - In cycle N+1, mem_doutb is pushed into the FIFO at the clock edge; inflight clears unless another read fired.
  - rdata_valid rises in cycle N+2. Minimum latency is 2; sustained throughput is 1 read/cycle with rdata_ready held high.
- Response FIFO:
  - 2 entries, in-order; rdata = head entry; rdata_valid = fifo_count > 0.
  - rdata and rdata_valid are held stable while rdata_ready = 0.
  - Simultaneous push and pop is legal at any occupancy; the space rule makes overflow impossible.
- Reset mid-operation: inflight reads and FIFO contents are discarded, and an init sweep restarts from address 0 (if INIT_EN).

Test Plan:
- INIT_EN=1, MEM_ADDRWIDTH=4, release reset -> init_busy high exactly 16 cycles, mem_addra 0..15 with dina=0 and wea all-ones; subsequent read of addr 5 returns 0.
- Write addr 3, data 0xFFFF…, mask 0x00FF…FF00, then read addr 3 -> rdata has masked bits =1 and others =0; rdata_valid 2 cycles after the rd fire.
- Same cycle write addr 7 = 0xA5 and read addr 7 -> rd_ready=0 that cycle; read issues next cycle and returns 0xA5.
- rdata_ready=0 with continuous reads -> exactly 2 reads accepted, then rd_ready=0. Raise rdata_ready -> responses in order, no loss or duplicates, then 1/cycle throughput.
- init_req while one read is in flight -> the response is still delivered; INIT starts the cycle after inflight clears; wr_ready/rd_ready low until init_busy falls.
- Assert reset during INIT at counter=9 -> sweep restarts from addr 0, full 16 cycles.

Source files
------------

// File: rtl/mem_tp_ctrl.sv
// mem_tp_ctrl: sequencing controller in front of a two-port bit-write memory (write port A, registered read port B)
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   init_req, init_busy               zero-fill sweep request pulse and pending/running flag
//   wr_valid/wr_ready/addr/mask/data  write request channel
//   rd_valid/rd_ready/rd_addr         read request channel
//   rdata_valid/rdata_ready/rdata     2-entry in-order read response buffer
//   mem_ena/wea/addra/dina            memory write port A
//   mem_enb/addrb/doutb               memory read port B, doutb valid the cycle after enb
module mem_tp_ctrl #(
    parameter int MEM_DATAWIDTH = 128,
    parameter int MEM_ADDRWIDTH = 14,
    parameter bit INIT_EN       = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_req,
    output logic                     init_busy,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [MEM_ADDRWIDTH-1:0] wr_addr,
    input  logic [MEM_DATAWIDTH-1:0] wr_mask,
    input  logic [MEM_DATAWIDTH-1:0] wr_data,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [MEM_ADDRWIDTH-1:0] rd_addr,
    output logic                     rdata_valid,
    input  logic                     rdata_ready,
    output logic [MEM_DATAWIDTH-1:0] rdata,
    output logic                     mem_ena,
    output logic [MEM_DATAWIDTH-1:0] mem_wea,
    output logic [MEM_ADDRWIDTH-1:0] mem_addra,
    output logic [MEM_DATAWIDTH-1:0] mem_dina,
    output logic                     mem_enb,
    output logic [MEM_ADDRWIDTH-1:0] mem_addrb,
    input  logic [MEM_DATAWIDTH-1:0] mem_doutb
);
    typedef enum logic {INIT, RUN} state_t;
    state_t                   state;
    logic [MEM_ADDRWIDTH-1:0] cnt;
    logic                     init_pend;
    logic                     inflight;
    logic [1:0]               count;
    logic [MEM_DATAWIDTH-1:0] fifo0, fifo1;
    logic                     in_init, run_ok, wr_fire, rd_fire, pop, space;
    logic [1:0]               slot;

    // reset gating keeps both channels and port A quiet during the reset cycle itself
    assign in_init     = !reset && state == INIT;
    assign run_ok      = !reset && state == RUN && !init_pend;
    assign wr_ready    = run_ok;
    assign wr_fire     = wr_valid && run_ok;
    assign pop         = rdata_valid && rdata_ready;
    // a read may only issue if its response is guaranteed a FIFO slot
    assign space       = ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    // same-address write wins; the read retries next cycle and sees the new data
    assign rd_ready    = run_ok && space && !(wr_fire && wr_addr == rd_addr);
    assign rd_fire     = rd_valid && rd_ready;
    assign init_busy   = state == INIT || init_pend;
    assign rdata_valid = count != 2'd0;
    assign rdata       = fifo0;
    assign mem_ena     = in_init || wr_fire;
    assign mem_wea     = in_init ? '1 : (wr_fire ? wr_mask : '0);
    assign mem_addra   = in_init ? cnt : wr_addr;
    assign mem_dina    = in_init ? '0 : wr_data;
    assign mem_enb     = rd_fire;
    assign mem_addrb   = rd_addr;
    // FIFO position the incoming response lands in, after any same-cycle pop
    assign slot        = count - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_EN ? INIT : RUN;
            cnt       <= '0;
            init_pend <= 1'b0;
            inflight  <= 1'b0;
            count     <= 2'd0;
        end else begin
            inflight <= rd_fire;
            count    <= count + {1'b0, inflight} - {1'b0, pop};
            if (pop) fifo0 <= fifo1;
            if (inflight && slot == 2'd0) fifo0 <= mem_doutb;
            if (inflight && slot != 2'd0) fifo1 <= mem_doutb;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (&cnt) state <= RUN;
            end else if (init_pend && !inflight) begin
                state     <= INIT;
                cnt       <= '0;
                init_pend <= 1'b0;
            end else if (init_req) begin
                init_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_tp_ctrl.sv
// tb_mem_tp_ctrl: randomized and directed scoreboard bench for mem_tp_ctrl with a behavioural memory
module tb_mem_tp_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0, reset = 1'b1, init_req = 1'b0;
    logic          init_busy;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_mask = '0, wr_data = '0;
    logic          rd_valid = 1'b0, rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rdata_valid, rdata_ready = 1'b1;
    logic [DW-1:0] rdata;
    logic          mem_ena, mem_enb;
    logic [DW-1:0] mem_wea, mem_dina;
    logic [AW-1:0] mem_addra, mem_addrb;
    logic [DW-1:0] mem_doutb;

    int tests = 0, fails = 0;

    mem_tp_ctrl #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .INIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .init_req(init_req), .init_busy(init_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb)
    );

    always #5 clk = ~clk;

    // the physical memory the controller drives
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_ena) mem[mem_addra] <= (mem[mem_addra] & ~mem_wea) | (mem_dina & mem_wea);
        if (mem_enb) mem_doutb <= mem[mem_addrb];
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // reference model: request-level memory contents and expected response order
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            if (rdata_valid && rdata_ready) begin
                if (exp_q.size() == 0) check("rdata_unexpected", rdata, 'x);
                else begin
                    e = exp_q.pop_front();
                    check("rdata", rdata, e);
                end
            end
            if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
            if (wr_valid && wr_ready) ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
            if (init_req) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // call at a negedge with init_busy high; walks until the sweep completes
    task automatic sweep(input string name);
        int n = 0;
        int k = 0;
        while (init_busy && k < 40) begin
            check({name, "_wr_ready"}, DW'(wr_ready), 0);
            check({name, "_rd_ready"}, DW'(rd_ready), 0);
            if (mem_ena) begin
                check({name, "_addra"}, DW'(mem_addra), DW'(n[AW-1:0]));
                check({name, "_wea"}, mem_wea, '1);
                check({name, "_dina"}, mem_dina, '0);
                n++;
            end
            @(negedge clk);
            k++;
        end
        check({name, "_cycles"}, DW'(n), 16);
        check({name, "_done"}, DW'(init_busy), 0);
    endtask

    task automatic drain();
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        rdata_ready = 1'b1;
        repeat (6) step();
    endtask

    logic [DW-1:0] held;
    int acc;

    initial begin
        // reset cycle
        @(negedge clk);
        check("rst_wr_ready", DW'(wr_ready), 0);
        check("rst_rd_ready", DW'(rd_ready), 0);
        check("rst_mem_ena", DW'(mem_ena), 0);
        check("rst_mem_enb", DW'(mem_enb), 0);
        check("rst_rdata_valid", DW'(rdata_valid), 0);
        check("rst_init_busy", DW'(init_busy), 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        sweep("init0");

        // read after init returns zero
        step();
        rd_valid = 1'b1;
        rd_addr = 4'd5;
        @(negedge clk);
        check("rd5_ready", DW'(rd_ready), 1);
        drain();

        // masked write then read, with exact latency
        step();
        wr_valid = 1'b1;
        wr_addr = 4'd3;
        wr_data = 32'hFFFF_FFFF;
        wr_mask = 32'h00FF_FF00;
        @(negedge clk);
        check("mask_wr_ready", DW'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr = 4'd3;
        @(negedge clk);
        check("mask_rd_ready", DW'(rd_ready), 1);
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", DW'(rdata_valid), 0);
        step();
        @(negedge clk);
        check("lat_n2_valid", DW'(rdata_valid), 1);
        check("mask_rdata", rdata, 32'h00FF_FF00);
        drain();

        // same-cycle same-address collision
        step();
        wr_valid = 1'b1;
        wr_addr = 4'd7;
        wr_data = 32'h0000_00A5;
        wr_mask = '1;
        rd_valid = 1'b1;
        rd_addr = 4'd7;
        @(negedge clk);
        check("coll_wr_ready", DW'(wr_ready), 1);
        check("coll_rd_ready", DW'(rd_ready), 0);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        check("coll_retry_ready", DW'(rd_ready), 1);
        step();
        rd_valid = 1'b0;
        step();
        @(negedge clk);
        check("coll_rdata", rdata, 32'h0000_00A5);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_mask = $urandom;
            wr_data = $urandom;
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            rdata_ready = $urandom_range(0, 3) != 0;
        end
        drain();
        check("rand_drained", DW'(exp_q.size()), 0);

        // backpressure: only two reads fit
        acc = 0;
        rdata_ready = 1'b0;
        rd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rd_addr = AW'(k);
            @(negedge clk);
            if (rd_ready) acc++;
            if (k == 2) held = rdata;
            if (k == 5) begin
                check("bp_rd_ready_low", DW'(rd_ready), 0);
                check("bp_valid_held", DW'(rdata_valid), 1);
                check("bp_rdata_held", rdata, held);
            end
            step();
        end
        check("bp_accepted", DW'(acc), 2);
        acc = 0;
        rdata_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_addr = AW'(k + 8);
            @(negedge clk);
            if (rd_ready) acc++;
            step();
        end
        check("throughput", DW'(acc), 8);
        drain();
        check("bp_drained", DW'(exp_q.size()), 0);

        // init request with a read in flight
        step();
        rd_valid = 1'b1;
        rd_addr = 4'd3;
        init_req = 1'b1;
        @(negedge clk);
        check("ireq_rd_ready", DW'(rd_ready), 1);
        step();
        rd_valid = 1'b0;
        init_req = 1'b0;
        wr_valid = 1'b1;
        wr_addr = 4'd2;
        wr_mask = '1;
        wr_data = 32'h1234_5678;
        @(negedge clk);
        check("ireq_busy", DW'(init_busy), 1);
        check("ireq_wr_ready", DW'(wr_ready), 0);
        check("ireq_n1_ena", DW'(mem_ena), 0);
        step();
        @(negedge clk);
        check("ireq_n2_ena", DW'(mem_ena), 0);
        check("ireq_n2_busy", DW'(init_busy), 1);
        step();
        @(negedge clk);
        check("ireq_n3_ena", DW'(mem_ena), 1);
        sweep("init1");
        drain();
        check("ireq_resp_delivered", DW'(exp_q.size()), 0);
        step();
        rd_valid = 1'b1;
        rd_addr = 4'd3;
        step();
        rd_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_init_rdata", rdata, '0);
        drain();

        // reset during a sweep at counter 9
        step();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        acc = 0;
        for (int k = 0; k < 40 && acc == 0; k++) begin
            @(negedge clk);
            if (mem_ena && mem_addra == 4'd9) acc = 1;
        end
        check("reach_cnt9", DW'(acc), 1);
        #1 reset = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_ena", DW'(mem_ena), 0);
        check("mid_rst_busy", DW'(init_busy), 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        sweep("init2");
        drain();
        check("final_drained", DW'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
